// File: rtl/frame_serialiser_pkg.sv
// Shared types and constants for the TPIU frame serialiser.
package frame_serialiser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam int FRAME_BYTES = 16;
  localparam logic [31:0] SYNC_WORD = 32'h7FFF_FFFF;

  // Sync word goes out least-significant byte first: FF FF FF 7F.
  function automatic logic [7:0] sync_byte(input logic [1:0] idx);
    return SYNC_WORD[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/frame_serialiser_byte_shifter.sv
// 128-bit frame holding register that shifts out one byte per accept,
// tracking the byte index and flagging the final byte.
module byte_shifter
  import frame_serialiser_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [FRAME_BYTES*8-1:0] load_data,
  input  logic                     shift,
  input  logic                     peek_next,
  output logic [7:0]               byte_out,
  output logic                     last
);

  logic [FRAME_BYTES*8-1:0] data;
  logic [3:0]               idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= '0;
    end else if (shift) begin
      idx <= idx + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {8'h00, data[FRAME_BYTES*8-1:8]};
    end
  end

  // peek_next exposes the byte that becomes current after the pending shift,
  // so the registered TxData can be preloaded on the same edge.
  assign byte_out = peek_next ? data[15:8] : data[7:0];
  assign last     = (idx == 4'(FRAME_BYTES - 1));

endmodule

// File: rtl/frame_serialiser.sv
// Pops 128-bit TPIU frames and streams them as bytes on a valid/ready link.
// Optional feature macro: FRAME_SYNC_EN (inserts sync word every SYNC_INTERVAL frames).
module frame_serialiser
  import frame_serialiser_pkg::*;
#(
  parameter int SYNC_INTERVAL = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] Frame,
  input  logic         FrameReady,
  output logic         FrameNext,
  input  logic         DataOverf,
  output logic [7:0]   TxData,
  output logic         TxValid,
  input  logic         TxReady,
  output logic         OverfSeen,
  output logic [15:0]  FramesSent
);

  if (SYNC_INTERVAL < 1 || SYNC_INTERVAL > 65535) begin : g_bad_interval
    $error("SYNC_INTERVAL out of range 1..65535");
  end

  state_t     state;
  logic       holdoff;
  logic       load;
  logic       shift;
  logic       peek_next;
  logic [7:0] shift_byte;
  logic       last;

`ifdef FRAME_SYNC_EN
  logic [15:0] sync_cnt;
  logic [1:0]  sync_idx;
  logic        sync_due;

  assign sync_due = (sync_cnt == 16'(SYNC_INTERVAL));
`endif

  assign load      = (state == ST_IDLE) && FrameReady && !holdoff;
  assign shift     = (state == ST_SEND) && TxReady;
  assign peek_next = (state == ST_SEND);

  byte_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (Frame),
    .shift     (shift),
    .peek_next (peek_next),
    .byte_out  (shift_byte),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      FrameNext  <= 1'b0;
      TxValid    <= 1'b0;
      TxData     <= 8'h00;
      OverfSeen  <= 1'b0;
      FramesSent <= 16'd0;
      holdoff    <= 1'b0;
`ifdef FRAME_SYNC_EN
      sync_cnt   <= 16'(SYNC_INTERVAL);
      sync_idx   <= 2'd0;
`endif
    end else begin
      FrameNext <= 1'b0;
      // packBuffer needs a cycle after a pop before FrameReady is meaningful.
      holdoff   <= FrameNext;
      if (DataOverf) begin
        OverfSeen <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (load) begin
            FrameNext <= 1'b1;
            TxValid   <= 1'b1;
`ifdef FRAME_SYNC_EN
            if (sync_due) begin
              state    <= ST_SYNC;
              TxData   <= sync_byte(2'd0);
              sync_idx <= 2'd0;
              sync_cnt <= 16'd1;
            end else begin
              state    <= ST_SEND;
              TxData   <= Frame[7:0];
              sync_cnt <= sync_cnt + 16'd1;
            end
`else
            state  <= ST_SEND;
            TxData <= Frame[7:0];
`endif
          end
        end
`ifdef FRAME_SYNC_EN
        ST_SYNC: begin
          if (TxReady) begin
            if (sync_idx == 2'd3) begin
              state  <= ST_SEND;
              TxData <= shift_byte;
            end else begin
              sync_idx <= sync_idx + 2'd1;
              TxData   <= sync_byte(sync_idx + 2'd1);
            end
          end
        end
`endif
        ST_SEND: begin
          if (TxReady) begin
            if (last) begin
              TxValid    <= 1'b0;
              state      <= ST_IDLE;
              FramesSent <= FramesSent + 16'd1;
            end else begin
              TxData <= shift_byte;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_serialiser.sv
// Directed bench for frame_serialiser; expectations follow FRAME_SYNC_EN when defined.
module tb_frame_serialiser;

`ifdef FRAME_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] Frame;
  logic         FrameReady;
  logic         FrameNext;
  logic         DataOverf;
  logic [7:0]   TxData;
  logic         TxValid;
  logic         TxReady;
  logic         OverfSeen;
  logic [15:0]  FramesSent;

  int errors = 0;
  int checks = 0;

  logic [127:0] frames [3];
  logic [7:0]   got [$];
  logic [7:0]   exp_q [$];
  int           pop_cyc [$];
  int           stall_bad;

  frame_serialiser #(.SYNC_INTERVAL(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .Frame      (Frame),
    .FrameReady (FrameReady),
    .FrameNext  (FrameNext),
    .DataOverf  (DataOverf),
    .TxData     (TxData),
    .TxValid    (TxValid),
    .TxReady    (TxReady),
    .OverfSeen  (OverfSeen),
    .FramesSent (FramesSent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic bit sync_before(input int i);
    return SYNC_ON && (i % 2 == 0);
  endfunction

  function automatic int frame_cycles(input int i);
    return sync_before(i) ? 21 : 17;
  endfunction

  task automatic build_expected(input int nfr);
    exp_q.delete();
    for (int i = 0; i < nfr; i++) begin
      if (sync_before(i)) begin
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h7F);
      end
      for (int b = 0; b < 16; b++) exp_q.push_back(8'(16 * (i % 3) + b));
    end
  endtask

  // Drives FrameReady/Frame like packBuffer and records accepted bytes and pops.
  task automatic collect(input int nbytes, input int nframes, input int mode, input int budget);
    int k = 0;
    int pops = 0;
    logic hold = 1'b0;
    logic [7:0] pdata = 8'h00;
    got.delete();
    pop_cyc.delete();
    stall_bad = 0;
    Frame = frames[0];
    FrameReady = 1'b1;
    while (got.size() < nbytes && k < budget) begin
      TxReady = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      if (FrameNext) begin
        pop_cyc.push_back(k);
        pops++;
        if (pops >= nframes) FrameReady = 1'b0;
        else Frame = frames[pops % 3];
      end
      if (hold && (TxValid !== 1'b1 || TxData !== pdata)) stall_bad++;
      if (TxValid && TxReady) got.push_back(TxData);
      hold = TxValid && !TxReady;
      pdata = TxData;
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    FrameReady = 1'b0; TxReady = 1'b1; DataOverf = 1'b0;
    do_reset();
    checks++; if (FrameNext !== 1'b0) begin errors++; $display("FAIL reset_framenext got=%b exp=0", FrameNext); end
    checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL reset_txvalid got=%b exp=0", TxValid); end
    checks++; if (TxData !== 8'h00) begin errors++; $display("FAIL reset_txdata got=%h exp=00", TxData); end
    checks++; if (OverfSeen !== 1'b0) begin errors++; $display("FAIL reset_overfseen got=%b exp=0", OverfSeen); end
    checks++; if (FramesSent !== 16'd0) begin errors++; $display("FAIL reset_framessent got=%0d exp=0", FramesSent); end
  endtask

  task automatic test_single_frame();
    do_reset();
    build_expected(1);
    collect(exp_q.size(), 1, 0, 100);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL single_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    checks++; if (pop_cyc.size() != 1) begin errors++; $display("FAIL single_pops got=%0d exp=1", pop_cyc.size()); end
    checks++; if (FramesSent !== 16'd1) begin errors++; $display("FAIL single_sent got=%0d exp=1", FramesSent); end
    checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL single_txvalid_after got=%b exp=0", TxValid); end
  endtask

  task automatic test_three_frames();
    do_reset();
    build_expected(3);
    collect(exp_q.size(), 3, 0, 200);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL three_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL three_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    checks++; if (pop_cyc.size() != 3) begin errors++; $display("FAIL three_pops got=%0d exp=3", pop_cyc.size()); end
    for (int i = 0; i + 1 < pop_cyc.size(); i++) begin
      checks++;
      if (pop_cyc[i+1] - pop_cyc[i] != frame_cycles(i)) begin
        errors++; $display("FAIL three_spacing[%0d] got=%0d exp=%0d", i, pop_cyc[i+1] - pop_cyc[i], frame_cycles(i));
      end
    end
    checks++; if (FramesSent !== 16'd3) begin errors++; $display("FAIL three_sent got=%0d exp=3", FramesSent); end
  endtask

  task automatic test_stall();
    do_reset();
    build_expected(1);
    collect(exp_q.size(), 1, 1, 300);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", stall_bad); end
    checks++; if (FramesSent !== 16'd1) begin errors++; $display("FAIL stall_sent got=%0d exp=1", FramesSent); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    build_expected(2);
    collect(exp_q.size(), 99, 0, 200);
    FrameReady = 1'b0;
    checks++; if (pop_cyc.size() != 2) begin errors++; $display("FAIL b2b_pops got=%0d exp=2", pop_cyc.size()); end
    checks++; if (pop_cyc.size() > 0 && pop_cyc[0] != 1) begin errors++; $display("FAIL b2b_first_pop got=%0d exp=1", pop_cyc[0]); end
    checks++;
    if (pop_cyc.size() > 1 && pop_cyc[1] - pop_cyc[0] != frame_cycles(0)) begin
      errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", pop_cyc[1] - pop_cyc[0], frame_cycles(0));
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    tick();
    checks++; if (FrameNext !== 1'b0) begin errors++; $display("FAIL b2b_no_extra_pop got=%b exp=0", FrameNext); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    collect(SYNC_ON ? 11 : 7, 1, 0, 100);
    checks++; if (TxData !== 8'h07) begin errors++; $display("FAIL mid_at_byte7 got=%h exp=07", TxData); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL mid_txvalid got=%b exp=0", TxValid); end
    checks++; if (FramesSent !== 16'd0) begin errors++; $display("FAIL mid_sent got=%0d exp=0", FramesSent); end
    build_expected(1);
    collect(exp_q.size(), 1, 0, 100);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL mid_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL mid_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    checks++; if (pop_cyc.size() != 1) begin errors++; $display("FAIL mid_pops got=%0d exp=1", pop_cyc.size()); end
    checks++; if (FramesSent !== 16'd1) begin errors++; $display("FAIL mid_sent_after got=%0d exp=1", FramesSent); end
  endtask

  task automatic test_overflow();
    do_reset();
    checks++; if (OverfSeen !== 1'b0) begin errors++; $display("FAIL overf_before got=%b exp=0", OverfSeen); end
    DataOverf = 1'b1;
    tick();
    DataOverf = 1'b0;
    checks++; if (OverfSeen !== 1'b1) begin errors++; $display("FAIL overf_set got=%b exp=1", OverfSeen); end
    repeat (5) tick();
    checks++; if (OverfSeen !== 1'b1) begin errors++; $display("FAIL overf_sticky got=%b exp=1", OverfSeen); end
    do_reset();
    checks++; if (OverfSeen !== 1'b0) begin errors++; $display("FAIL overf_cleared got=%b exp=0", OverfSeen); end
  endtask

  initial begin
    rst = 1'b1; Frame = '0; FrameReady = 1'b0; DataOverf = 1'b0; TxReady = 1'b1;
    for (int j = 0; j < 3; j++)
      for (int b = 0; b < 16; b++) frames[j][b*8 +: 8] = 8'(16 * j + b);
    test_reset();
    test_single_frame();
    test_three_frames();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_serialiser.md
# frame_serialiser

Downstream consumer of `packBuffer`: pops 128-bit TPIU frames via the `FrameReady`/`FrameNext` handshake and emits each as 16 bytes on a byte-wide valid/ready stream toward the host link (FTDI/SPI/UART back end). Optionally inserts a TPIU sync word so the host can realign. Also latches buffer overflow and counts frames sent for status reporting.

## Interface
- `SYNC_INTERVAL`, 16: frames between inserted sync words (only with `FRAME_SYNC_EN`; legal 1..65535).
- `clk  in  1`: sole clock; same domain as `packBuffer`.
- `rst  in  1`: synchronous, active-high reset.
- `Frame  in  128`: frame from `packBuffer`; valid while `FrameReady`=1.
- `FrameReady  in  1`: `packBuffer` holds a frame.
- `FrameNext  out  1`: one-cycle pop pulse to `packBuffer`.
- `DataOverf  in  1`: `packBuffer` overflow flag.
- `TxData  out  8`: output byte.
- `TxValid  out  1`: `TxData` valid.
- `TxReady  in  1`: sink accepts byte when `TxValid`&&`TxReady`.
- `OverfSeen  out  1`: sticky copy of `DataOverf`.
- `FramesSent  out  16`: count of frames fully emitted, wraps 0xFFFF->0.

## Operation
- States: IDLE, SYNC (macro only), SEND.
- IDLE: if `FrameReady`=1 and `holdoff`=0 -> capture `Frame` into 128-bit shift register, assert `FrameNext` for exactly one cycle, byte index <= 0; next state SYNC if sync due, else SEND.
- `holdoff`: set the cycle after any `FrameNext` pulse; `FrameReady` ignored that cycle (`packBuffer` needs one cycle to update).
- SEND: `TxValid`=1, `TxData`=shift[7:0]. On accept: shift right 8, index+1. On accept of index 15: `FramesSent`+1, -> IDLE.
- Byte order: byte 0 = `Frame[7:0]`, byte 15 = `Frame[127:120]`.
- SYNC: emits 0xFF,0xFF,0xFF,0x7F in that order with the same handshake, then -> SEND with captured frame intact.
- `OverfSeen` set on any cycle with `DataOverf`=1; cleared only by `rst`.
- Never pop a frame until the previous one is fully accepted; no prefetch.

## Timing
- Reset values: `FrameNext`=0, `TxValid`=0, `TxData`=0x00, `OverfSeen`=0, `FramesSent`=0, state IDLE, `holdoff`=0, sync counter = "due".
- All outputs registered. `FrameReady` seen high at edge N -> `FrameNext`=1 and `TxValid`=1 during cycle after N.
- With `TxReady` held 1: 16 cycles per frame in SEND + 1 IDLE cycle = 17 cycles/frame (21 when sync inserted).
- While `TxValid`=1 and `TxReady`=0, `TxData` and `TxValid` hold stable; `TxValid` never drops before accept.
- `rst` mid-frame: next cycle `TxValid`=0, state IDLE; popped frame is discarded (not re-requested).
- `FrameReady` dropping while in SEND/SYNC has no effect.
- `FramesSent` increment and 0xFFFF->0 wrap occur on the index-15 accept edge.

## Configuration
- `FRAME_SYNC_EN` defined: SYNC state and a frame counter present; sync emitted before the first frame after reset and before every `SYNC_INTERVAL`-th frame thereafter (frame counter resets to 0 on each sync).
- Undefined: no SYNC state, no counter; `SYNC_INTERVAL` ignored; output is pure frame bytes.

## Structure
- Package `frame_serialiser_pkg`: state enum, `FRAME_BYTES`=16, `SYNC_WORD`=32'h7FFFFFFF (emitted LSB byte first).
- One sub-module: `byte_shifter` — 128-bit load/shift register with 4-bit byte index and `last` flag; the FSM lives in the top.

## Test plan
- Single frame 0x0F0E…0100, `TxReady`=1, macro off -> bytes 0x00,0x01…0x0F, one `FrameNext` pulse, `FramesSent`=1.
- Same frame, macro on, `SYNC_INTERVAL`=2, three frames -> FF FF FF 7F, frame0, frame1, FF FF FF 7F, frame2.
- `TxReady` toggled 1,0,0,1 per cycle -> `TxData` stable across stalls; 16 bytes in order; no duplicate or skipped byte.
- `FrameReady` held high continuously -> exactly one `FrameNext` per frame, 17-cycle spacing, none in the holdoff cycle.
- `rst` asserted at byte 7 -> `TxValid`=0 next cycle, `FramesSent`=0; next frame starts at byte 0 (with sync if macro on).
- `DataOverf` pulsed one cycle -> `OverfSeen`=1 and stays 1 until `rst`.
